// File: rtl/gmii_rx_frame_aligner.sv
// rtl/gmii_rx_frame_aligner.sv - GMII receive preamble/SFD stripper and payload framer
//
// Purpose: registers raw GMII receive bytes, locks onto preamble/SFD and emits
// only the payload bytes with sof/eof framing, byte count and error status.
// Latency from a payload byte on the pins to valid_o is a fixed 3 cycles and a
// frame is contiguous on valid_o. Optional saturating statistics counters are
// built when the macro GMII_RX_FRAME_STATS_EN is defined; otherwise the counter
// ports are tied to 0.
//
// Ports:
//   clk, rst_n                          receive clock, asynchronous active-low reset
//   gmii_rxd_i, gmii_rx_dv_i, gmii_rx_er_i  raw GMII receive pins
//   data_o, valid_o                     payload byte stream
//   sof_o, eof_o                        first / last payload byte (qualified by valid_o)
//   err_o, len_o                        frame status, meaningful on valid_o & eof_o
//   drop_o                              one-cycle pulse per discarded frame
//   good_cnt_o, bad_cnt_o, drop_cnt_o   frame statistics
module gmii_rx_frame_aligner #(
   parameter int PRE_MIN = 1,
   parameter int MAX_LEN = 1522,
   parameter int LEN_W   = 11,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        gmii_rxd_i,
   input  logic              gmii_rx_dv_i,
   input  logic              gmii_rx_er_i,
   output logic [7:0]        data_o,
   output logic              valid_o,
   output logic              sof_o,
   output logic              eof_o,
   output logic              err_o,
   output logic [LEN_W-1:0]  len_o,
   output logic              drop_o,
   output logic [STAT_W-1:0] good_cnt_o,
   output logic [STAT_W-1:0] bad_cnt_o,
   output logic [STAT_W-1:0] drop_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_DROP} state_t;

   localparam logic [7:0]       PRE_BYTE  = 8'h55;
   localparam logic [7:0]       SFD_BYTE  = 8'hD5;
   localparam logic [3:0]       PRE_MIN_C = 4'(PRE_MIN);
   localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

   // input stage
   logic [7:0]       rxd_q, rxd_d;
   logic             dv_q, dv_d, er_q, er_d;
   logic             in_vld_q, in_vld_d;
   // framing state
   state_t           state_q, state_d;
   logic [3:0]       pcnt_q, pcnt_d;
   logic [7:0]       hold_q, hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             err_sticky_q, err_sticky_d;
   logic             sup_q, sup_d;
   logic             first_q, first_d;
   // output registers
   logic [7:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sof_q, out_sof_d;
   logic             out_eof_q, out_eof_d;
   logic             out_err_q, out_err_d;
   logic [LEN_W-1:0] out_len_q, out_len_d;
   logic             out_drop_q, out_drop_d;

   logic is_pre, is_sfd, sfd_ok;

   assign is_pre = dv_q && !er_q && (rxd_q == PRE_BYTE);
   assign is_sfd = dv_q && !er_q && (rxd_q == SFD_BYTE);
   assign sfd_ok = is_sfd && (((state_q == S_IDLE) && (PRE_MIN == 0)) ||
                              ((state_q == S_PREAMBLE) && (pcnt_q >= PRE_MIN_C)));

   // in_vld marks that in_q holds a real pin sample; right after reset the
   // cleared dv=0 would otherwise let DROP fall to IDLE in the middle of a frame.
   always_comb begin
      rxd_d    = gmii_rxd_i;
      dv_d     = gmii_rx_dv_i;
      er_d     = gmii_rx_er_i;
      in_vld_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_q        <= '0;
         dv_q         <= 1'b0;
         er_q         <= 1'b0;
         in_vld_q     <= 1'b0;
         state_q      <= S_DROP;
         pcnt_q       <= '0;
         hold_q       <= '0;
         hold_vld_q   <= 1'b0;
         len_q        <= '0;
         err_sticky_q <= 1'b0;
         sup_q        <= 1'b1;
         first_q      <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         out_err_q    <= 1'b0;
         out_len_q    <= '0;
         out_drop_q   <= 1'b0;
      end else begin
         rxd_q        <= rxd_d;
         dv_q         <= dv_d;
         er_q         <= er_d;
         in_vld_q     <= in_vld_d;
         state_q      <= state_d;
         pcnt_q       <= pcnt_d;
         hold_q       <= hold_d;
         hold_vld_q   <= hold_vld_d;
         len_q        <= len_d;
         err_sticky_q <= err_sticky_d;
         sup_q        <= sup_d;
         first_q      <= first_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_sof_q    <= out_sof_d;
         out_eof_q    <= out_eof_d;
         out_err_q    <= out_err_d;
         out_len_q    <= out_len_d;
         out_drop_q   <= out_drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (dv_q) begin
               if (is_pre)      state_d = S_PREAMBLE;
               else if (sfd_ok) state_d = S_PAYLOAD;
               else             state_d = S_DROP;
            end
         S_PREAMBLE:
            if (!dv_q)       state_d = S_IDLE;
            else if (is_pre) state_d = S_PREAMBLE;
            else if (sfd_ok) state_d = S_PAYLOAD;
            else             state_d = S_DROP;
         S_PAYLOAD:
            if (!dv_q)                  state_d = S_IDLE;
            else if (len_q == MAX_LEN_C) state_d = S_DROP;
         S_DROP:
            if (in_vld_q && !dv_q) state_d = S_IDLE;
         default: state_d = S_DROP;
      endcase
   end

   // One byte is always kept in hold so the last byte can be tagged eof when
   // dv falls, keeping the output stream gap-free.
   always_comb begin
      pcnt_d       = pcnt_q;
      hold_d       = hold_q;
      hold_vld_d   = hold_vld_q;
      len_d        = len_q;
      err_sticky_d = err_sticky_q;
      sup_d        = sup_q;
      first_d      = first_q;
      out_data_d   = '0;
      out_valid_d  = 1'b0;
      out_sof_d    = 1'b0;
      out_eof_d    = 1'b0;
      out_err_d    = 1'b0;
      out_len_d    = '0;
      out_drop_d   = 1'b0;
      if (sfd_ok) begin
         len_d        = '0;
         err_sticky_d = 1'b0;
         hold_vld_d   = 1'b0;
         first_d      = 1'b1;
      end
      case (state_q)
         S_IDLE:
            if (is_pre) pcnt_d = 4'd1;
         S_PREAMBLE: begin
            if (is_pre && pcnt_q != 4'hF) pcnt_d = pcnt_q + 4'd1;
            if (!dv_q) out_drop_d = 1'b1;
         end
         S_PAYLOAD: begin
            if (hold_vld_q) begin
               out_valid_d = 1'b1;
               out_data_d  = hold_q;
               out_sof_d   = first_q;
               first_d     = 1'b0;
            end
            if (dv_q && len_q == MAX_LEN_C) begin
               // truncation: already reported through eof, so no drop pulse
               out_eof_d  = 1'b1;
               out_err_d  = 1'b1;
               out_len_d  = MAX_LEN_C;
               hold_vld_d = 1'b0;
               sup_d      = 1'b1;
            end else if (dv_q) begin
               hold_d     = rxd_q;
               hold_vld_d = 1'b1;
               len_d      = len_q + LEN_W'(1);
               if (er_q) err_sticky_d = 1'b1;
            end else if (hold_vld_q) begin
               out_eof_d  = 1'b1;
               out_err_d  = err_sticky_q;
               out_len_d  = len_q;
               hold_vld_d = 1'b0;
            end else begin
               out_drop_d = 1'b1;
            end
         end
         S_DROP:
            if (in_vld_q && !dv_q) begin
               out_drop_d = !sup_q;
               sup_d      = 1'b0;
            end
         default: ;
      endcase
   end

   assign data_o  = out_data_q;
   assign valid_o = out_valid_q;
   assign sof_o   = out_sof_q;
   assign eof_o   = out_eof_q;
   assign err_o   = out_err_q;
   assign len_o   = out_len_q;
   assign drop_o  = out_drop_q;

`ifdef GMII_RX_FRAME_STATS_EN
   logic [STAT_W-1:0] good_q, good_d, bad_q, bad_d, dropc_q, dropc_d;

   // Counters follow the output registers' next values so they move on the
   // same edge as the eof/drop they count.
   always_comb begin
      good_d  = good_q;
      bad_d   = bad_q;
      dropc_d = dropc_q;
      if (out_valid_d && out_eof_d && !out_err_d && good_q != {STAT_W{1'b1}})
         good_d = good_q + STAT_W'(1);
      if (out_valid_d && out_eof_d && out_err_d && bad_q != {STAT_W{1'b1}})
         bad_d = bad_q + STAT_W'(1);
      if (out_drop_d && dropc_q != {STAT_W{1'b1}})
         dropc_d = dropc_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_q  <= '0;
         bad_q   <= '0;
         dropc_q <= '0;
      end else begin
         good_q  <= good_d;
         bad_q   <= bad_d;
         dropc_q <= dropc_d;
      end
   end

   assign good_cnt_o = good_q;
   assign bad_cnt_o  = bad_q;
   assign drop_cnt_o = dropc_q;
`else
   assign good_cnt_o = '0;
   assign bad_cnt_o  = '0;
   assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_aligner.sv
// tb/tb_gmii_rx_frame_aligner.sv - bench for gmii_rx_frame_aligner (default and MAX_LEN=16 instances)
module tb_gmii_rx_frame_aligner;

   localparam int DMAX = 1522;
   localparam int TMAX = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       dv;
      logic       er;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rxd = 8'h00;
   logic        dv = 1'b0;
   logic        er = 1'b0;

   logic [7:0]  d0_data, d1_data;
   logic        d0_valid, d0_sof, d0_eof, d0_err, d0_drop;
   logic        d1_valid, d1_sof, d1_eof, d1_err, d1_drop;
   logic [10:0] d0_len, d1_len;
   logic [31:0] d0_good, d0_bad, d0_dropc, d1_good, d1_bad, d1_dropc;

   int n_pass = 0;
   int n_checks = 0;
   int cyc = 0;
   int eg[2], eb[2], ed[2];

   stim_t             stim_q[$];
   longint unsigned   obs_q[$];
   longint unsigned   exp_q[$];

   gmii_rx_frame_aligner dut0 (
      .clk(clk), .rst_n(rst_n),
      .gmii_rxd_i(rxd), .gmii_rx_dv_i(dv), .gmii_rx_er_i(er),
      .data_o(d0_data), .valid_o(d0_valid), .sof_o(d0_sof), .eof_o(d0_eof),
      .err_o(d0_err), .len_o(d0_len), .drop_o(d0_drop),
      .good_cnt_o(d0_good), .bad_cnt_o(d0_bad), .drop_cnt_o(d0_dropc)
   );

   gmii_rx_frame_aligner #(.MAX_LEN(TMAX)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .gmii_rxd_i(rxd), .gmii_rx_dv_i(dv), .gmii_rx_er_i(er),
      .data_o(d1_data), .valid_o(d1_valid), .sof_o(d1_sof), .eof_o(d1_eof),
      .err_o(d1_err), .len_o(d1_len), .drop_o(d1_drop),
      .good_cnt_o(d1_good), .bad_cnt_o(d1_bad), .drop_cnt_o(d1_dropc)
   );

   always #4 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // event word: cycle | dut | drop | data | sof | eof | err | len
   function automatic longint unsigned mk(input int c, input int dut, input bit drp,
                                          input logic [7:0] d, input bit sof, input bit eof,
                                          input bit err, input int len);
      return {24'(c), 1'(dut), drp, d, sof, eof, err, 11'(len), 16'h0000};
   endfunction

   always @(negedge clk) begin
      if (d0_valid) obs_q.push_back(mk(cyc, 0, 1'b0, d0_data, d0_sof, d0_eof, d0_eof & d0_err, d0_eof ? int'(d0_len) : 0));
      if (d0_drop)  obs_q.push_back(mk(cyc, 0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0));
      if (d1_valid) obs_q.push_back(mk(cyc, 1, 1'b0, d1_data, d1_sof, d1_eof, d1_eof & d1_err, d1_eof ? int'(d1_len) : 0));
      if (d1_drop)  obs_q.push_back(mk(cyc, 1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0));
   end

   function automatic void push_frame(input int npre, input int plen, input logic [7:0] first,
                                      input bit rnd, input int er_at, input logic [7:0] sfd);
      for (int k = 0; k < npre + 1 + plen; k++) begin
         stim_t s;
         if (k < npre)       s.d = 8'h55;
         else if (k == npre) s.d = sfd;
         else if (rnd)       s.d = 8'($urandom);
         else                s.d = first + 8'(k - npre - 1);
         s.dv = 1'b1;
         s.er = (k == er_at);
         stim_q.push_back(s);
      end
   endfunction

   function automatic void push_byte(input logic [7:0] d);
      stim_t s;
      s.d = d; s.dv = 1'b1; s.er = 1'b0;
      stim_q.push_back(s);
   endfunction

   function automatic void push_idle(input int n);
      stim_t s;
      s.d = 8'h00; s.dv = 1'b0; s.er = 1'b0;
      for (int k = 0; k < n; k++) stim_q.push_back(s);
   endfunction

   // Frame-level reference: each dv burst is either a good preamble+SFD with a
   // non-empty payload (delivered, maybe truncated) or a single discarded frame.
   // Stimulus item k is on the pins in cycle base+k.
   function automatic void model(input int base);
      int n, i, s, e, j, plen, nout, mx;
      bit ok, ferr, last;
      n = stim_q.size();
      i = 0;
      while (i < n) begin
         if (!stim_q[i].dv) begin
            i++;
            continue;
         end
         s = i;
         e = i;
         while (e < n && stim_q[e].dv) e++;
         j = s;
         while (j < e && stim_q[j].d == 8'h55 && !stim_q[j].er) j++;
         ok = (j < e) && (stim_q[j].d == 8'hD5) && !stim_q[j].er && ((j - s) >= 1) && ((e - j - 1) > 0);
         for (int u = 0; u < 2; u++) begin
            mx = (u == 0) ? DMAX : TMAX;
            if (!ok) begin
               exp_q.push_back(mk(base + e + 2, u, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0));
               ed[u]++;
            end else begin
               plen = e - j - 1;
               nout = (plen > mx) ? mx : plen;
               ferr = (plen > mx);
               for (int k = 0; k < plen; k++) if (stim_q[j + 1 + k].er) ferr = 1'b1;
               for (int k = 0; k < nout; k++) begin
                  last = (k == nout - 1);
                  exp_q.push_back(mk(base + j + 1 + k + 3, u, 1'b0, stim_q[j + 1 + k].d,
                                     k == 0, last, last & ferr, last ? nout : 0));
               end
               if (ferr) eb[u]++;
               else      eg[u]++;
            end
         end
         i = e;
      end
   endfunction

   task automatic run_stim();
      int base;
      obs_q.delete();
      exp_q.delete();
      base = 0;
      foreach (stim_q[k]) begin
         @(posedge clk);
         #1;
         if (k == 0) base = cyc;
         rxd = stim_q[k].d;
         dv  = stim_q[k].dv;
         er  = stim_q[k].er;
      end
      model(base);
      stim_q.delete();
      obs_q.sort();
      exp_q.sort();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      n_checks++;
      if ({d0_data, d0_valid, d0_sof, d0_eof, d0_err, d0_len, d0_drop, d0_good, d0_bad, d0_dropc} !== '0)
         $display("FAIL reset_dut0 got valid=%0b drop=%0b len=%0d want all zero", d0_valid, d0_drop, d0_len);
      else n_pass++;
      n_checks++;
      if ({d1_data, d1_valid, d1_sof, d1_eof, d1_err, d1_len, d1_drop, d1_good, d1_bad, d1_dropc} !== '0)
         $display("FAIL reset_dut1 got valid=%0b drop=%0b len=%0d want all zero", d1_valid, d1_drop, d1_len);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_normal();
      longint unsigned got;
      int nv;
      push_idle(2);
      push_frame(7, 64, 8'h00, 1'b0, -1, 8'hD5);
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL normal n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL normal event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
      nv = 0;
      foreach (obs_q[i]) if (!obs_q[i][39] && !obs_q[i][38]) nv++;
      n_checks++;
      if (nv != 64) $display("FAIL normal dut0_valid_bytes got %0d want 64", nv);
      else n_pass++;
   endtask

   task automatic test_rx_error();
      longint unsigned got;
      push_frame(7, 20, 8'h30, 1'b1, 7 + 1 + 10, 8'hD5);
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL rx_error n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL rx_error event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_bad_preamble();
      longint unsigned got;
      push_byte(8'h55);
      push_byte(8'h55);
      push_byte(8'h12);
      push_byte(8'hD5);
      for (int k = 0; k < 10; k++) push_byte(8'(k + 1));
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL bad_preamble n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL bad_preamble event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_truncation();
      longint unsigned got;
      push_frame(7, 20, 8'h40, 1'b0, -1, 8'hD5);
      push_idle(1);
      push_frame(7, 4, 8'h80, 1'b0, -1, 8'hD5);
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL truncation n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL truncation event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      longint unsigned got;
      push_frame(7, 1, 8'hA1, 1'b0, -1, 8'hD5);
      push_idle(1);
      push_frame(7, 1, 8'hA2, 1'b0, -1, 8'hD5);
      push_idle(1);
      push_frame(7, 1, 8'hA3, 1'b0, -1, 8'hD5);
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL back_to_back n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL back_to_back event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      longint unsigned got;
      int npre, plen, er_at;
      logic [7:0] sfd;
      for (int f = 0; f < 16; f++) begin
         npre = int'($urandom_range(0, 9));
         plen = int'($urandom_range(0, 40));
         sfd  = ($urandom_range(0, 7) == 0) ? 8'h5D : 8'hD5;
         if ($urandom_range(0, 4) == 0) er_at = int'($urandom_range(0, npre + plen));
         else                           er_at = -1;
         push_frame(npre, plen, 8'h00, 1'b1, er_at, sfd);
         push_idle(int'($urandom_range(1, 3)));
      end
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL random n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL random event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_stats();
      int got[6];
      int want[6];
      got = '{int'(d0_good), int'(d0_bad), int'(d0_dropc), int'(d1_good), int'(d1_bad), int'(d1_dropc)};
`ifdef GMII_RX_FRAME_STATS_EN
      want = '{eg[0], eb[0], ed[0], eg[1], eb[1], ed[1]};
`else
      want = '{0, 0, 0, 0, 0, 0};
`endif
      for (int u = 0; u < 6; u++) begin
         n_checks++;
         if (got[u] !== want[u]) $display("FAIL stats_cnt%0d got %0d want %0d", u, got[u], want[u]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      longint unsigned got;
      push_frame(7, 12, 8'h10, 1'b0, -1, 8'hD5);
      push_idle(8);
      obs_q.delete();
      foreach (stim_q[k]) begin
         @(posedge clk);
         #1;
         rxd = stim_q[k].d;
         dv  = stim_q[k].dv;
         er  = stim_q[k].er;
         if (k == 13) rst_n = 1'b0;
         if (k == 13 || k == 15) begin
            #1;
            n_checks++;
            if ({d0_data, d0_valid, d0_sof, d0_eof, d0_err, d0_len, d0_drop, d0_good, d0_bad, d0_dropc} !== '0)
               $display("FAIL mid_reset_dut0 item%0d got valid=%0b data=%h want all zero", k, d0_valid, d0_data);
            else n_pass++;
            n_checks++;
            if ({d1_data, d1_valid, d1_sof, d1_eof, d1_err, d1_len, d1_drop, d1_good, d1_bad, d1_dropc} !== '0)
               $display("FAIL mid_reset_dut1 item%0d got valid=%0b data=%h want all zero", k, d1_valid, d1_data);
            else n_pass++;
            obs_q.delete();
         end
         if (k == 16) rst_n = 1'b1;
      end
      stim_q.delete();
      n_checks++;
      if (obs_q.size() != 0) $display("FAIL mid_reset_quiet got %0d events want 0", obs_q.size());
      else n_pass++;
      n_checks++;
      if ({d0_good, d0_bad, d0_dropc, d1_good, d1_bad, d1_dropc} !== '0)
         $display("FAIL mid_reset_stats got %0d/%0d/%0d want 0/0/0", d0_good, d0_bad, d0_dropc);
      else n_pass++;
      eg = '{0, 0};
      eb = '{0, 0};
      ed = '{0, 0};
      push_frame(7, 6, 8'hC0, 1'b0, -1, 8'hD5);
      push_idle(8);
      run_stim();
      n_checks++;
      if (obs_q.size() != exp_q.size()) $display("FAIL after_reset n_events got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
         got = (i < obs_q.size()) ? obs_q[i] : 64'h0;
         n_checks++;
         if (got !== exp_q[i]) $display("FAIL after_reset event%0d got %h want %h", i, got, exp_q[i]);
         else n_pass++;
      end
   endtask

   initial begin
      eg = '{0, 0};
      eb = '{0, 0};
      ed = '{0, 0};
      test_reset();
      test_normal();
      test_rx_error();
      test_bad_preamble();
      test_truncation();
      test_back_to_back();
      test_random();
      test_stats();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
